// File: rtl/vga_fb_arbiter_if.sv
// Host-side write port of the cell framebuffer; readback signals exist only
// when FB_READBACK_EN is defined.
interface vga_fb_arbiter_if #(
  parameter int unsigned COL_W = 7,
  parameter int unsigned ROW_W = 6
);
  logic             w_valid;
  logic             w_ready;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [8:0]       w_data;
`ifdef FB_READBACK_EN
  logic             rd_valid;
  logic             rd_ready;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic [8:0]       rd_data;
  logic             rd_data_valid;

  modport master (output w_valid, w_col, w_row, w_data, input w_ready,
                  output rd_valid, rd_col, rd_row,
                  input rd_ready, rd_data, rd_data_valid);
  modport slave  (input w_valid, w_col, w_row, w_data, output w_ready,
                  input rd_valid, rd_col, rd_row,
                  output rd_ready, rd_data, rd_data_valid);
`else
  modport master (output w_valid, w_col, w_row, w_data, input w_ready);
  modport slave  (input w_valid, w_col, w_row, w_data, output w_ready);
`endif
endinterface

// File: rtl/vga_fb_arbiter.sv
// Cell framebuffer for vga_controller: single-port RAM shared between display
// fetches (always win) and host writes. FB_READBACK_EN adds a host read port.
module vga_fb_arbiter #(
  parameter int unsigned H_MAX      = 800,
  parameter int unsigned V_MAX      = 525,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned CELL_SHIFT = 3
) (
  input  logic                     i_Clk,
  input  logic                     rst_n,
  input  logic [$clog2(H_MAX)-1:0] x_pos,
  input  logic [$clog2(V_MAX)-1:0] y_pos,
  input  logic                     valid_pos,
  vga_fb_arbiter_if.slave          host,
  output logic [2:0]               r_pxl,
  output logic [2:0]               g_pxl,
  output logic [2:0]               b_pxl
);
  localparam int unsigned XW    = $clog2(H_MAX);
  localparam int unsigned YW    = $clog2(V_MAX);
  localparam int unsigned COLS  = H_ACTIVE >> CELL_SHIFT;
  localparam int unsigned ROWS  = V_ACTIVE >> CELL_SHIFT;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam logic [CELL_SHIFT-1:0] SLOT_PH = CELL_SHIFT'((1 << CELL_SHIFT) - 2);

  logic [8:0]    mem [CELLS] = '{default: '0};
  logic [8:0]    ram_q;
  logic [AW-1:0] ram_addr;
  logic          ram_re;
  logic          ram_we;

  logic          slot;
  logic          w_ready;
  logic [XW:0]   tx;
  logic [YW:0]   ty;
  logic          fetch_in;
  logic [AW-1:0] disp_addr;
  logic          wr_acc;
  logic          wr_in;
  logic [AW-1:0] wr_addr;

  logic          fetch_vld_q;
  logic          fetch_in_q;
  logic [8:0]    pix_q, pix_d;

  assign slot         = (x_pos[CELL_SHIFT-1:0] == SLOT_PH);
  assign w_ready      = rst_n && !slot;
  assign host.w_ready = w_ready;
  assign wr_acc       = host.w_valid && w_ready;
  assign wr_in        = (32'(host.w_col) < COLS) && (32'(host.w_row) < ROWS);
  assign wr_addr      = AW'(32'(host.w_row) * COLS + 32'(host.w_col));

  // Slot fetches the cell two pixels ahead, wrapping across line and frame ends.
  always_comb begin
    tx = {1'b0, x_pos} + (XW+1)'(2);
    ty = {1'b0, y_pos};
    if (tx == (XW+1)'(H_MAX)) begin
      tx = '0;
      ty = {1'b0, y_pos} + (YW+1)'(1);
      if (ty == (YW+1)'(V_MAX)) ty = '0;
    end
    fetch_in  = (32'(tx) < H_ACTIVE) && (32'(ty) < V_ACTIVE);
    disp_addr = AW'(32'(ty >> CELL_SHIFT) * COLS + 32'(tx >> CELL_SHIFT));
  end

`ifdef FB_READBACK_EN
  logic          rd_acc;
  logic          rd_in;
  logic [AW-1:0] rd_addr;
  logic          rd_vld_q;
  logic          rd_in_q;

  assign host.rd_ready      = w_ready && !host.w_valid;
  assign rd_acc             = host.rd_valid && host.rd_ready;
  assign rd_in              = (32'(host.rd_col) < COLS) && (32'(host.rd_row) < ROWS);
  assign rd_addr            = AW'(32'(host.rd_row) * COLS + 32'(host.rd_col));
  assign host.rd_data       = rd_in_q ? ram_q : '0;
  assign host.rd_data_valid = rd_vld_q;

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_in_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) rd_in_q <= rd_in;
    end
  end
`endif

  // One address mux: slot cycles belong to the display, others to the host.
  always_comb begin
    ram_addr = disp_addr;
    ram_re   = slot && fetch_in;
    ram_we   = 1'b0;
    if (!slot) begin
      if (wr_acc) begin
        ram_addr = wr_addr;
        ram_we   = wr_in;
      end
`ifdef FB_READBACK_EN
      else if (rd_acc) begin
        ram_addr = rd_addr;
        ram_re   = rd_in;
      end
`endif
    end
  end

  always_ff @(posedge i_Clk) begin
    if (ram_we) mem[ram_addr] <= host.w_data;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  always_comb begin
    pix_d = pix_q;
    if (fetch_vld_q) pix_d = fetch_in_q ? ram_q : '0;
  end

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_vld_q <= 1'b0;
      fetch_in_q  <= 1'b0;
      pix_q       <= '0;
    end else begin
      fetch_vld_q <= slot;
      fetch_in_q  <= fetch_in;
      pix_q       <= pix_d;
    end
  end

  assign {r_pxl, g_pxl, b_pxl} = valid_pos ? pix_q : 9'd0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: raster positions are driven directly and
// a due-cycle queue predicts each pixel register load.
module tb_vga_fb_arbiter;
  localparam int H_MAX = 800, V_MAX = 525, H_ACTIVE = 640, V_ACTIVE = 480;
  localparam int COLS = 80, ROWS = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic       valid_pos = 1'b0;
  logic [2:0] r_pxl, g_pxl, b_pxl;

  vga_fb_arbiter_if #(.COL_W(7), .ROW_W(6)) hif ();

  vga_fb_arbiter #(
    .H_MAX(H_MAX), .V_MAX(V_MAX), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .CELL_SHIFT(3)
  ) dut (
    .i_Clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos), .valid_pos(valid_pos),
    .host(hif), .r_pxl(r_pxl), .g_pxl(g_pxl), .b_pxl(b_pxl)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [8:0] val;} sb_t;
  sb_t        sbq[$];
  logic [8:0] model [COLS*ROWS];
  logic [8:0] cur_exp = '0;
  int         cyc_n = 0;
  int         checks = 0;
  int         errors = 0;
  int         cur_x, cur_y;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s x=%0d y=%0d observed=%h expected=%h", tag, cur_x, cur_y, obs, exp);
    end
  endtask

  // One pixel clock at (x,y); entered and left at posedge+1.
  task automatic cyc(input int x, input int y, input bit rst_drop = 1'b0);
    bit slot, exp_rdy, acc;
    int tx, ty;
    sb_t e;
    x_pos = 10'(x); y_pos = 10'(y);
    valid_pos = (x < H_ACTIVE) && (y < V_ACTIVE);
    cur_x = x; cur_y = y;
    if (rst_drop) begin
      #1 rst_n = 1'b0;
    end
    @(negedge clk);
    slot    = (x % 8) == 6;
    exp_rdy = rst_n && !slot;
    while (sbq.size() > 0 && sbq[0].due < cyc_n) void'(sbq.pop_front());
    if (sbq.size() > 0 && sbq[0].due == cyc_n) begin
      e = sbq.pop_front();
      cur_exp = e.val;
    end
    if (!rst_n) begin
      sbq.delete();
      cur_exp = '0;
    end
    check("pix", {r_pxl, g_pxl, b_pxl}, valid_pos ? cur_exp : 9'd0);
    check("w_ready", {8'd0, hif.w_ready}, {8'd0, exp_rdy});
    if (slot && rst_n) begin
      tx = x + 2; ty = y;
      if (tx == H_MAX) begin
        tx = 0; ty = y + 1;
        if (ty == V_MAX) ty = 0;
      end
      e.due = cyc_n + 2;
      e.val = (tx < H_ACTIVE && ty < V_ACTIVE) ? model[(ty / 8) * COLS + tx / 8] : 9'd0;
      sbq.push_back(e);
    end
    acc = hif.w_valid && exp_rdy;
    if (acc && int'(hif.w_col) < COLS && int'(hif.w_row) < ROWS)
      model[int'(hif.w_row) * COLS + int'(hif.w_col)] = hif.w_data;
    @(posedge clk);
    #1;
    cyc_n++;
    if (acc) hif.w_valid = 1'b0;
  endtask

  task automatic do_write(input int col, input int row, input logic [8:0] data);
    hif.w_valid = 1'b1;
    hif.w_col   = 7'(col);
    hif.w_row   = 6'(row);
    hif.w_data  = data;
    cyc(100, 490);
    check("w_accept", {8'd0, hif.w_valid}, 9'd0);
    hif.w_valid = 1'b0;
  endtask

  initial begin
    foreach (model[i]) model[i] = '0;
    hif.w_valid = 1'b0; hif.w_col = '0; hif.w_row = '0; hif.w_data = '0;
`ifdef FB_READBACK_EN
    hif.rd_valid = 1'b0; hif.rd_col = '0; hif.rd_row = '0;
`endif
    @(posedge clk); #1;
    cyc(10, 10); cyc(14, 10); cyc(15, 10);
    rst_n = 1'b1;
    cyc(16, 10); cyc(17, 10);

    // Cell (0,0) written in vertical blanking.
    do_write(0, 0, 9'b111_000_101);

    // Request raised on a slot cycle: refused there, taken the next clock.
    for (int x = 0; x < 16; x++) begin
      if (x == 6) begin
        hif.w_valid = 1'b1; hif.w_col = 7'd3; hif.w_row = 6'd12; hif.w_data = 9'h0C3;
      end
      cyc(x, 100);
    end
    check("stall_done", {8'd0, hif.w_valid}, 9'd0);

    do_write(1, 1, 9'h1FF);
    do_write(80, 0, 9'h1FF);
    do_write(37, 25, 9'h155);
    do_write(38, 25, 9'h0F0);
    do_write(39, 25, 9'h0AB);

    // Whole-frame scan, each cell row entered from the end of the line above.
    for (int r = 0; r < ROWS; r++) begin
      for (int x = 792; x < 800; x++) cyc(x, (r == 0) ? V_MAX - 1 : r * 8 - 1);
      for (int x = 0; x < H_ACTIVE; x++) cyc(x, r * 8);
    end

    // Asynchronous reset mid-line, released before the slot at x=310.
    for (int x = 288; x < 300; x++) cyc(x, 200);
    cyc(300, 200, 1'b1);
    for (int x = 301; x < 304; x++) cyc(x, 200);
    rst_n = 1'b1;
    for (int x = 304; x < 328; x++) cyc(x, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Cell-based framebuffer feeding vga_controller's pixel inputs.
- Owns a single-port RAM of 3/3/3-bit RGB cells (one cell = 2^CELL_SHIFT square pixels).
- Arbitrates each clock between display fetches, which always win, and a host write requester (UART/game logic) on a valid/ready handshake.
- Registered pixel outputs connect directly to r_pxl_value/g_pxl_value/b_pxl_value.

Parameters:
H_MAX, 800, total pixel clocks per line; must be a multiple of 2^CELL_SHIFT
V_MAX, 525, total lines per frame
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines
CELL_SHIFT, 3, log2 of cell edge in pixels; derived COLS=H_ACTIVE>>CELL_SHIFT (80), ROWS=V_ACTIVE>>CELL_SHIFT (60), CELLS=COLS*ROWS

Ports:
i_Clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
x_pos  in  $clog2(H_MAX)  controller horizontal count (0..H_MAX-1)
y_pos  in  $clog2(V_MAX)  controller vertical count (0..V_MAX-1)
valid_pos  in  1  active-region flag from controller (unused for scheduling; gates outputs)
w_valid  in  1  host write request
w_ready  out  1  write accepted this cycle when w_valid&&w_ready
w_col  in  $clog2(COLS)  target cell column
w_row  in  $clog2(ROWS)  target cell row
w_data  in  9  {r[2:0],g[2:0],b[2:0]}
r_pxl  out  3  red to controller
g_pxl  out  3  green to controller
b_pxl  out  3  blue to controller

Behaviour:
- Clock is i_Clk. Reset is asynchronous, active-low on rst_n: pixel register=0, fetch pipeline valid=0, w_ready=0 while rst_n=0. RAM contents are not reset (zero-initialised for simulation).
- Display slot: any cycle with x_pos[CELL_SHIFT-1:0]==2^CELL_SHIFT-2.
  - Target pixel tx=x_pos+2, ty=y_pos.
  - If tx==H_MAX, then tx=0 and ty=y_pos+1; if that ty==V_MAX, then ty=0.
  - Fetch is issued only if tx<H_ACTIVE and ty<V_ACTIVE. Address = (ty>>CELL_SHIFT)*COLS + (tx>>CELL_SHIFT).
- Fetch pipeline:
  - Slot cycle t: RAM read.
  - t+1: data valid.
  - Rising edge ending t+1: data loads the pixel register, visible from x_pos[CELL_SHIFT-1:0]==0, i.e. exactly at the target pixel.
  - A slot whose target is out of the active region loads 0 instead.
- Output: {r_pxl,g_pxl,b_pxl}=pixel register when valid_pos=1, else 0. Each cell value is held for 2^CELL_SHIFT clocks.
- Arbiter:
  - w_ready = rst released && not a display slot.
  - w_ready is combinational from x_pos only and does not depend on w_valid.
  - A write is accepted when w_valid&&w_ready and reaches the RAM in the same cycle.
  - A read in a later cycle returns the new data.
- Writes with w_col>=COLS or w_row>=ROWS are accepted (handshake completes) and discarded.
- Host must hold w_valid/w_col/w_row/w_data stable until accepted. A stalled request is accepted on the next non-slot cycle, at most 1 cycle of stall per slot.
- Display and write never share a cycle, so the RAM needs one port and one address mux.
- Reset asserted mid-line: in-flight fetch is dropped, outputs read 0 until the first slot after release loads the pixel register. No partial write can occur.

Optional Feature:
FB_READBACK_EN
- Defined: adds ports rd_valid(in,1), rd_ready(out,1), rd_col, rd_row (in, same widths as w_col/w_row), rd_data(out,9), rd_data_valid(out,1).
  - Reads are granted in non-slot cycles only.
  - A pending write has priority over a read in the same cycle, so rd_ready = w_ready && !w_valid.
  - rd_data/rd_data_valid are registered one cycle after acceptance. rd_data_valid is a 1-cycle pulse; its reset value is 0.
  - Out-of-range reads return 0 with rd_data_valid=1.
- Undefined: ports are absent and arbiter logic is write-only.

Test Plan:
1. Reset, then write (col0,row0)=9'b111_000_101 during vertical blanking. Next frame: x=0..7, y=0..7 give r=7, g=0, b=5; x=8 gives 0.
2. Hold w_valid with x_pos=6, y=100. Required: w_ready=0 at x=6; accepted at x=7; no other cycle stalled.
3. Write (col1,row1)=9'h1FF. At x=798, y=7, the fetch targets row1 col0. At y=8: x=8..15 output 7/7/7, and x=0..7 output the stored col0 value.
4. Fetch at x=798, y=524 targets (0,0). Output at x=0, y=0 of the next frame equals cell (0,0).
5. Write w_col=80 with data 9'h1FF. Handshake completes; no cell changes across a full-frame scan.
6. Assert rst_n low at x=300, y=200. Outputs are 0 and w_ready=0 immediately (asynchronous). After release, the first valid pixel appears at the next x mod 8==0 following a slot.
